// File: rtl/shrv_seq_pkg.sv
// Shared types and default stage numbering for the stage sequencer.
// Stage indices follow the classic five-phase fetch/decode/execute/memory/writeback order.
package shrv_seq_pkg;

   typedef enum logic [1:0] {
      RUN  = 2'd0,
      HALT = 2'd1,
      ERR  = 2'd2
   } seq_state_e;

   localparam int ST_FT = 0;
   localparam int ST_DC = 1;
   localparam int ST_EX = 2;
   localparam int ST_MA = 3;
   localparam int ST_WB = 4;

endpackage

// File: rtl/stage_sequencer_if.sv
// Control/status bundle between the core controller and the stage sequencer.
// master drives hold/skip/flush/halt_req; slave (the sequencer) drives the stage outputs.
interface stage_sequencer_if #(
   parameter int NUM_STAGES = 5,
   parameter int CNT_W      = 16
);
   localparam int IDX_W = (NUM_STAGES > 1) ? $clog2(NUM_STAGES) : 1;

   logic [NUM_STAGES-1:0] hold;
   logic [NUM_STAGES-1:0] skip;
   logic                  flush;
   logic                  halt_req;

   logic [NUM_STAGES-1:0] stage_en;
   logic [NUM_STAGES-1:0] stage_fire;
   logic [IDX_W-1:0]      cur_stage;
   logic                  retire;
   logic                  halted;
   logic                  timeout_err;
   logic [CNT_W-1:0]      inst_cycles;

   modport master (
      output hold, skip, flush, halt_req,
      input  stage_en, stage_fire, cur_stage, retire, halted, timeout_err, inst_cycles
   );

   modport slave (
      input  hold, skip, flush, halt_req,
      output stage_en, stage_fire, cur_stage, retire, halted, timeout_err, inst_cycles
   );

endinterface

// File: rtl/seq_next_stage.sv
// Finds the lowest non-skipped stage above cur; wrap=1 when none exists (next is stage 0).
// Purely combinational; skip[0] never matters since stage 0 is always entered on wrap.
module seq_next_stage #(
   parameter int NUM_STAGES = 5,
   parameter int IDX_W      = 3
) (
   input  logic [IDX_W-1:0]      cur,
   input  logic [NUM_STAGES-1:0] skip,
   output logic [IDX_W-1:0]      nxt,
   output logic                  wrap
);

   logic unused_skip0;
   assign unused_skip0 = skip[0];

   // Descending scan so the last hit is the lowest qualifying index.
   always_comb begin
      nxt  = '0;
      wrap = 1'b1;
      for (int k = NUM_STAGES - 1; k >= 1; k--) begin
         if ((k > int'(cur)) && !skip[k]) begin
            nxt  = IDX_W'(k);
            wrap = 1'b0;
         end
      end
   end

endmodule

// File: rtl/stage_sequencer.sv
// One-hot multi-cycle stage sequencer with hold/skip, flush, halt at instruction boundary and a hold watchdog.
// stage_fire/retire are combinational from state, hold and flush; every other output is registered.
module stage_sequencer
   import shrv_seq_pkg::*;
#(
   parameter int NUM_STAGES  = 5,
   parameter int TIMEOUT_CYC = 255,
   parameter int CNT_W       = 16
) (
   input logic               clk,
   input logic               rst,
   stage_sequencer_if.slave  bus
);

   localparam int IDX_W = (NUM_STAGES > 1) ? $clog2(NUM_STAGES) : 1;
   localparam int WD_W  = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
   localparam logic [WD_W-1:0]  WD_LIMIT = (TIMEOUT_CYC > 0) ? WD_W'(TIMEOUT_CYC - 1) : '0;
   localparam logic [CNT_W-1:0] CNT_MAX  = '1;

   seq_state_e            state_q, state_nxt;
   logic [IDX_W-1:0]      cur_q, cur_nxt;
   logic [NUM_STAGES-1:0] en_q, en_nxt;
   logic [WD_W-1:0]       wd_q, wd_nxt;
   logic [CNT_W-1:0]      icnt_q, icnt_nxt;
   logic [CNT_W-1:0]      inst_q, inst_nxt;
   logic                  halted_q, terr_q;

   logic [IDX_W-1:0]      srch_nxt;
   logic                  srch_wrap;
   logic                  run, held, wd_trip;
   logic [CNT_W-1:0]      icnt_inc;
   logic [NUM_STAGES-1:0] fire_c;
   logic                  retire_c;

   seq_next_stage #(
      .NUM_STAGES (NUM_STAGES),
      .IDX_W      (IDX_W)
   ) u_next (
      .cur  (cur_q),
      .skip (bus.skip),
      .nxt  (srch_nxt),
      .wrap (srch_wrap)
   );

   assign run      = (state_q == RUN) && !rst;
   assign held     = bus.hold[cur_q];
   // The trip cycle is the last held cycle that brings the count to the limit.
   assign wd_trip  = (TIMEOUT_CYC > 0) && run && held && (wd_q == WD_LIMIT);
   assign icnt_inc = (icnt_q == CNT_MAX) ? icnt_q : icnt_q + 1'b1;

   always_comb begin
      state_nxt = state_q;
      cur_nxt   = cur_q;
      wd_nxt    = wd_q;
      icnt_nxt  = icnt_q;
      inst_nxt  = inst_q;
      fire_c    = '0;
      retire_c  = 1'b0;

      unique case (state_q)
         RUN: begin
            if (bus.flush) begin
               cur_nxt  = '0;
               wd_nxt   = '0;
               icnt_nxt = '0;
            end else if (wd_trip) begin
               state_nxt = ERR;
            end else if (held) begin
               wd_nxt   = wd_q + 1'b1;
               icnt_nxt = icnt_inc;
            end else begin
               fire_c[cur_q] = run;
               wd_nxt        = '0;
               if (srch_wrap) begin
                  retire_c = run;
                  inst_nxt = icnt_inc;
                  icnt_nxt = '0;
                  cur_nxt  = '0;
                  if (bus.halt_req) begin
                     state_nxt = HALT;
                  end
               end else begin
                  cur_nxt  = srch_nxt;
                  icnt_nxt = icnt_inc;
               end
            end
         end
         HALT: begin
            if (!bus.flush && !bus.halt_req) begin
               state_nxt = RUN;
               cur_nxt   = '0;
            end
         end
         ERR: begin
            state_nxt = ERR;
         end
         default: begin
            state_nxt = ERR;
         end
      endcase

      en_nxt = (state_nxt == RUN) ? (NUM_STAGES'(1) << cur_nxt) : '0;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= RUN;
         cur_q    <= IDX_W'(ST_FT);
         en_q     <= NUM_STAGES'(1);
         wd_q     <= '0;
         icnt_q   <= '0;
         inst_q   <= '0;
         halted_q <= 1'b0;
         terr_q   <= 1'b0;
      end else begin
         state_q  <= state_nxt;
         cur_q    <= cur_nxt;
         en_q     <= en_nxt;
         wd_q     <= wd_nxt;
         icnt_q   <= icnt_nxt;
         inst_q   <= inst_nxt;
         halted_q <= (state_nxt == HALT);
         terr_q   <= (state_nxt == ERR);
      end
   end

   // en_q resets to stage 0 so the first post-reset cycle is already active; mask it while in reset.
   assign bus.stage_en    = en_q & {NUM_STAGES{~rst}};
   assign bus.stage_fire  = fire_c;
   assign bus.retire      = retire_c;
   assign bus.cur_stage   = cur_q;
   assign bus.halted      = halted_q;
   assign bus.timeout_err = terr_q;
   assign bus.inst_cycles = inst_q;

endmodule

// File: tb/tb_stage_sequencer.sv
// Directed bench: a default-parameter sequencer and a TIMEOUT_CYC=4 copy driven with identical stimulus.
module tb_stage_sequencer;

   logic       clk = 1'b0;
   logic       rst;
   logic [4:0] hold, skip;
   logic       flush, halt_req;
   int         n_assert = 0;
   int         n_fail   = 0;

   stage_sequencer_if #(.NUM_STAGES(5), .CNT_W(16)) bus_d ();
   stage_sequencer_if #(.NUM_STAGES(5), .CNT_W(16)) bus_w ();

   assign bus_d.hold = hold;  assign bus_d.skip = skip;
   assign bus_d.flush = flush; assign bus_d.halt_req = halt_req;
   assign bus_w.hold = hold;  assign bus_w.skip = skip;
   assign bus_w.flush = flush; assign bus_w.halt_req = halt_req;

   stage_sequencer u_def (.clk(clk), .rst(rst), .bus(bus_d));
   stage_sequencer #(.NUM_STAGES(5), .TIMEOUT_CYC(4), .CNT_W(16)) u_wd (.clk(clk), .rst(rst), .bus(bus_w));

   always #5 clk = ~clk;

   logic [4:0] t2_hold [7] = '{5'd0, 5'd0, 5'd4, 5'd4, 5'd4, 5'd0, 5'd0};
   logic [4:0] t2_en   [7] = '{5'd1, 5'd2, 5'd4, 5'd4, 5'd4, 5'd4, 5'd16};
   logic [4:0] t2_fire [7] = '{5'd1, 5'd2, 5'd0, 5'd0, 5'd0, 5'd4, 5'd16};

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Apply hold for one cycle, check the cycle's outputs, then move to the next cycle.
   task automatic step(input logic [4:0] h, input logic [4:0] en_e, input logic [4:0] fire_e,
                       input logic ret_e, input logic both, input string tag);
      hold = h;
      #1;
      chk({tag, " en"},     32'(bus_d.stage_en),   32'(en_e));
      chk({tag, " fire"},   32'(bus_d.stage_fire), 32'(fire_e));
      chk({tag, " retire"}, 32'(bus_d.retire),     32'(ret_e));
      if (both) begin
         chk({tag, " w en"},   32'(bus_w.stage_en),   32'(en_e));
         chk({tag, " w fire"}, 32'(bus_w.stage_fire), 32'(fire_e));
      end
      @(posedge clk); #1;
   endtask

   initial begin
      #100000;
      $display("FAIL global timeout: simulation did not complete");
      $fatal(1, "timeout");
   end

   initial begin
      rst = 1'b1; hold = '0; skip = '0; flush = 1'b0; halt_req = 1'b0;
      repeat (2) @(posedge clk);
      #2;
      chk("rst en",     32'(bus_d.stage_en),    32'd0);
      chk("rst fire",   32'(bus_d.stage_fire),  32'd0);
      chk("rst retire", 32'(bus_d.retire),      32'd0);
      chk("rst halted", 32'(bus_d.halted),      32'd0);
      chk("rst terr",   32'(bus_d.timeout_err), 32'd0);
      chk("rst inst",   32'(bus_d.inst_cycles), 32'd0);
      chk("rst cur",    32'(bus_d.cur_stage),   32'd0);
      rst = 1'b0;

      // Plain walk through all five stages
      for (int i = 0; i < 5; i++) step(5'd0, 5'(1 << i), 5'(1 << i), i == 4, 1'b1, "t1");
      chk("t1 inst", 32'(bus_d.inst_cycles), 32'd5);

      // MA skipped, EX held three cycles
      skip = 5'b01000;
      for (int i = 0; i < 7; i++) step(t2_hold[i], t2_en[i], t2_fire[i], i == 6, 1'b1, "t2");
      skip = 5'b00000;
      chk("t2 inst", 32'(bus_d.inst_cycles), 32'd7);

      // Flush in MA
      step(5'd0, 5'd1, 5'd1, 1'b0, 1'b1, "t3 ft");
      step(5'd0, 5'd2, 5'd2, 1'b0, 1'b1, "t3 dc");
      step(5'd0, 5'd4, 5'd4, 1'b0, 1'b1, "t3 ex");
      flush = 1'b1;
      step(5'd0, 5'd8, 5'd0, 1'b0, 1'b1, "t3 flush");
      flush = 1'b0;
      chk("t3 cur", 32'(bus_d.cur_stage), 32'd0);
      chk("t3 inst kept", 32'(bus_d.inst_cycles), 32'd7);
      for (int i = 0; i < 5; i++) step(5'd0, 5'(1 << i), 5'(1 << i), i == 4, 1'b1, "t3 walk");
      chk("t3 inst", 32'(bus_d.inst_cycles), 32'd5);

      // Halt requested mid-instruction
      step(5'd0, 5'd1, 5'd1, 1'b0, 1'b1, "t4 ft");
      halt_req = 1'b1;
      step(5'd0, 5'd2,  5'd2,  1'b0, 1'b1, "t4 dc");
      step(5'd0, 5'd4,  5'd4,  1'b0, 1'b1, "t4 ex");
      step(5'd0, 5'd8,  5'd8,  1'b0, 1'b1, "t4 ma");
      step(5'd0, 5'd16, 5'd16, 1'b1, 1'b1, "t4 wb");
      chk("t4 halted", 32'(bus_d.halted), 32'd1);
      chk("t4 inst",   32'(bus_d.inst_cycles), 32'd5);
      step(5'd0, 5'd0, 5'd0, 1'b0, 1'b1, "t4 halt1");
      flush = 1'b1;
      step(5'd0, 5'd0, 5'd0, 1'b0, 1'b1, "t4 halt flush");
      flush = 1'b0;
      chk("t4 halted flush", 32'(bus_d.halted), 32'd1);
      halt_req = 1'b0;
      step(5'd0, 5'd0, 5'd0, 1'b0, 1'b1, "t4 release");
      chk("t4 resumed", 32'(bus_d.halted), 32'd0);
      step(5'd0, 5'd1, 5'd1, 1'b0, 1'b1, "t4 ft2");

      // Reset while EX is held
      step(5'd0, 5'd2, 5'd2, 1'b0, 1'b1, "t5 dc");
      step(5'd4, 5'd4, 5'd0, 1'b0, 1'b1, "t5 hold");
      rst = 1'b1;
      step(5'd4, 5'd0, 5'd0, 1'b0, 1'b1, "t5 rst0");
      chk("t5 terr", 32'(bus_w.timeout_err), 32'd0);
      chk("t5 inst", 32'(bus_d.inst_cycles), 32'd0);
      chk("t5 cur",  32'(bus_d.cur_stage),   32'd0);
      step(5'd4, 5'd0, 5'd0, 1'b0, 1'b1, "t5 rst1");
      rst = 1'b0;
      step(5'd0, 5'd1, 5'd1, 1'b0, 1'b1, "t5 ft");

      // Watchdog: MA stuck
      step(5'd0, 5'd2, 5'd2, 1'b0, 1'b1, "t6 dc");
      step(5'd0, 5'd4, 5'd4, 1'b0, 1'b1, "t6 ex");
      for (int i = 0; i < 4; i++) step(5'd8, 5'd8, 5'd0, 1'b0, 1'b1, "t6 held");
      chk("t6 terr",   32'(bus_w.timeout_err), 32'd1);
      chk("t6 w en",   32'(bus_w.stage_en),    32'd0);
      chk("t6 halted", 32'(bus_w.halted),      32'd0);
      chk("t6 d terr", 32'(bus_d.timeout_err), 32'd0);
      flush = 1'b1;
      step(5'd8, 5'd8, 5'd0, 1'b0, 1'b0, "t6 flush");
      flush = 1'b0;
      chk("t6 terr flush", 32'(bus_w.timeout_err), 32'd1);
      chk("t6 w en flush", 32'(bus_w.stage_en),    32'd0);
      chk("t6 d en flush", 32'(bus_d.stage_en),    32'd1);
      rst = 1'b1;
      step(5'd0, 5'd0, 5'd0, 1'b0, 1'b1, "t6 rst0");
      chk("t6 terr rst", 32'(bus_w.timeout_err), 32'd0);
      step(5'd0, 5'd0, 5'd0, 1'b0, 1'b1, "t6 rst1");
      rst = 1'b0;

      // Every stage but fetch skipped: one-cycle instructions
      skip = 5'b11111;
      step(5'd0, 5'd1, 5'd1, 1'b1, 1'b1, "t7 a");
      chk("t7 inst", 32'(bus_d.inst_cycles), 32'd1);
      step(5'd0, 5'd1, 5'd1, 1'b1, 1'b1, "t7 b");
      chk("t7 w inst", 32'(bus_w.inst_cycles), 32'd1);
      skip = 5'b00000;

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
